// File: rtl/seq_lock.sv
// Combination lock: one-hot button presses sampled on a slow tick are compared
// against a programmable code, with fail counting, timed lockout and a program mode.
module seq_lock #(
  parameter int unsigned NBTN          = 3,
  parameter int unsigned CODE_LEN      = 4,
  parameter int unsigned TICK_DIV      = 50000000,
  parameter int unsigned MAX_FAIL      = 3,
  parameter int unsigned LOCKOUT_TICKS = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NBTN-1:0]                   b,
  input  logic                              prog,
  output logic                              unlock,
  output logic                              locked_out,
  output logic [3:0]                        state,
  output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt
);

  localparam int unsigned DW = $clog2(NBTN);
  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned FW = $clog2(MAX_FAIL + 1);
  localparam int unsigned LW = $clog2(LOCKOUT_TICKS + 1);
  localparam int unsigned IW = 4;

  typedef enum logic [1:0] {S_ENTER, S_OPEN, S_PROG, S_LOCKOUT} fsm_t;

  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [NBTN-1:0] b_smp;
  logic            armed;
  logic [NBTN-1:0] press;
  logic            any_press;
  logic            one_hot;
  logic [DW-1:0]   digit;
  logic [DW-1:0]   code_cur;
  logic            last;
  logic            hit;

  fsm_t            fsm_q, fsm_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            match_q, match_d;
  logic [FW-1:0]   fail_d;
  logic [LW-1:0]   lock_q, lock_d;
  logic [3:0]      state_d;
  logic            wr_c;
  logic            commit_c;

  logic [DW-1:0]   code_q   [CODE_LEN];
  logic [DW-1:0]   shadow_q [CODE_LEN];

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  // Free-running tick divider and tick-qualified button sampling
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      b_smp    <= '0;
      armed    <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      if (tick) begin
        b_smp <= b;
        armed <= 1'b1;
      end
    end
  end

  // The first tick after reset only primes the sample, so held buttons are not presses
  always_comb begin
    press     = armed ? (b & ~b_smp) : '0;
    any_press = |press;
    one_hot   = any_press && ((press & (press - NBTN'(1))) == '0);
    digit     = '0;
    for (int i = 0; i < int'(NBTN); i++) begin
      if (press[i]) digit = DW'(i);
    end
    code_cur = '0;
    for (int k = 0; k < int'(CODE_LEN); k++) begin
      if (idx_q == IW'(k)) code_cur = code_q[k];
    end
    last = (idx_q == IW'(CODE_LEN - 1));
    hit  = one_hot && (digit == code_cur);
  end

  always_comb begin
    fsm_d    = fsm_q;
    idx_d    = idx_q;
    match_d  = match_q;
    fail_d   = fail_cnt;
    lock_d   = lock_q;
    wr_c     = 1'b0;
    commit_c = 1'b0;
    state_d  = '0;
    if (tick) begin
      case (fsm_q)
        S_ENTER: begin
          if (any_press) begin
            if (!last) begin
              idx_d   = idx_q + IW'(1);
              match_d = match_q && hit;
            end else if (match_q && hit) begin
              fsm_d  = S_OPEN;
              fail_d = '0;
              idx_d  = '0;
            end else if (32'(fail_cnt) + 32'd1 < MAX_FAIL) begin
              fail_d  = fail_cnt + FW'(1);
              idx_d   = '0;
              match_d = 1'b1;
            end else begin
              fsm_d  = S_LOCKOUT;
              fail_d = FW'(MAX_FAIL);
              idx_d  = '0;
              lock_d = '0;
            end
          end
        end
        S_OPEN: begin
          if (prog) begin
            fsm_d = S_PROG;
            idx_d = '0;
          end else if (any_press) begin
            fsm_d   = S_ENTER;
            idx_d   = '0;
            match_d = 1'b1;
          end
        end
        S_PROG: begin
          if (one_hot) begin
            wr_c = 1'b1;
            if (last) begin
              commit_c = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
          // A completing digit commits even when prog drops on the same tick
          if (commit_c || !prog) begin
            fsm_d = S_OPEN;
            idx_d = '0;
          end
        end
        S_LOCKOUT: begin
          if (lock_q == LW'(LOCKOUT_TICKS - 1)) begin
            fsm_d   = S_ENTER;
            fail_d  = '0;
            idx_d   = '0;
            match_d = 1'b1;
          end else begin
            lock_d = lock_q + LW'(1);
          end
        end
        default: fsm_d = S_ENTER;
      endcase
    end
    case (fsm_d)
      S_ENTER:   state_d = idx_d;
      S_OPEN:    state_d = 4'hA;
      S_PROG:    state_d = 4'hB;
      S_LOCKOUT: state_d = 4'hC;
      default:   state_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q      <= S_ENTER;
      idx_q      <= '0;
      match_q    <= 1'b1;
      fail_cnt   <= '0;
      lock_q     <= '0;
      unlock     <= 1'b0;
      locked_out <= 1'b0;
      state      <= '0;
    end else begin
      fsm_q      <= fsm_d;
      idx_q      <= idx_d;
      match_q    <= match_d;
      fail_cnt   <= fail_d;
      lock_q     <= lock_d;
      unlock     <= (fsm_d == S_OPEN) || (fsm_d == S_PROG);
      locked_out <= (fsm_d == S_LOCKOUT);
      state      <= state_d;
    end
  end

  // Code store and program shadow; the final digit bypasses the shadow on commit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(CODE_LEN); k++) begin
        code_q[k]   <= DW'(k % int'(NBTN));
        shadow_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(CODE_LEN); k++) begin
        if (wr_c && (idx_q == IW'(k))) shadow_q[k] <= digit;
        if (commit_c) code_q[k] <= (idx_q == IW'(k)) ? digit : shadow_q[k];
      end
    end
  end

endmodule

// File: tb/tb_seq_lock.sv
// Scoreboard bench for seq_lock: directed button/prog vectors push expected outputs,
// a monitor compares them after every tick and checks outputs hold between ticks.
module tb_seq_lock;
  localparam int unsigned NBTN = 3, CODE_LEN = 4, TICK_DIV = 4, MAX_FAIL = 3, LOCKOUT_TICKS = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] b = 3'b000;
  logic       prog = 1'b0;
  logic       unlock, locked_out;
  logic [3:0] state;
  logic [1:0] fail_cnt;

  seq_lock #(.NBTN(NBTN), .CODE_LEN(CODE_LEN), .TICK_DIV(TICK_DIV),
             .MAX_FAIL(MAX_FAIL), .LOCKOUT_TICKS(LOCKOUT_TICKS)) dut (
    .clk(clk), .rst(rst), .b(b), .prog(prog), .unlock(unlock),
    .locked_out(locked_out), .state(state), .fail_cnt(fail_cnt));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       ul;
    logic       lo;
    logic [1:0] fc;
  } exp_t;

  exp_t q[$];
  exp_t cur = '0;
  exp_t ref_v = '0;
  bit   ref_ok = 1'b0;
  int   n_chk = 0, n_pass = 0;
  int   ph = 0, rst_evt = 0, rst_seen = 0;
  bit   tick_last = 1'b0;
  event tick_done;

  function automatic exp_t mk(input logic [3:0] st, input logic ul, input logic lo, input logic [1:0] fc);
    exp_t e;
    e.st = st; e.ul = ul; e.lo = lo; e.fc = fc;
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".state"}, int'(state), int'(e.st));
    chk({tag, ".unlock"}, int'(unlock), int'(e.ul));
    chk({tag, ".locked_out"}, int'(locked_out), int'(e.lo));
    chk({tag, ".fail_cnt"}, int'(fail_cnt), int'(e.fc));
  endtask

  // Independent tick phase model: tick edge is every TICK_DIV-th edge after reset
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph <= 0;
      tick_last <= 1'b0;
      rst_evt <= rst_evt + 1;
    end else begin
      tick_last <= (ph == int'(TICK_DIV) - 1);
      ph <= (ph == int'(TICK_DIV) - 1) ? 0 : ph + 1;
    end
  end

  // Monitor: pop one expectation per tick; between ticks outputs must hold
  always @(negedge clk) begin
    if (!rst || rst_evt != rst_seen) begin
      rst_seen = rst_evt;
      ref_v = '0;
      ref_ok = 1'b1;
    end
    if (rst) begin
      if (tick_last) begin
        if (q.size() > 0) begin
          ref_v = q.pop_front();
          ref_ok = 1'b1;
          chk_out("tick", ref_v);
        end
        ->tick_done;
      end else if (ref_ok) begin
        chk_out("hold", ref_v);
      end
    end
  end

  task automatic tk(input logic [2:0] bv, input logic pv, input exp_t e);
    b = bv;
    prog = pv;
    q.push_back(e);
    cur = e;
    @(tick_done);
  endtask

  // Release all buttons for one tick, then press
  task automatic pr(input logic [2:0] bv, input logic pv, input exp_t e);
    tk(3'b000, pv, cur);
    tk(bv, pv, e);
  endtask

  task automatic fail_ones(input logic [1:0] f0);
    for (int f = int'(f0); f < 3; f++) begin
      pr(3'b010, 1'b0, mk(4'd1, 0, 0, 2'(f)));
      pr(3'b010, 1'b0, mk(4'd2, 0, 0, 2'(f)));
      pr(3'b010, 1'b0, mk(4'd3, 0, 0, 2'(f)));
      pr(3'b010, 1'b0, (f < 2) ? mk(4'd0, 0, 0, 2'(f + 1)) : mk(4'hC, 0, 1, 2'd3));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not complete, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_out("reset", '0);
    #1 rst = 1'b1;

    // arm, then correct default code 0,1,2,0
    tk(3'b000, 0, mk(4'd0, 0, 0, 0));
    tk(3'b001, 0, mk(4'd1, 0, 0, 0));
    tk(3'b010, 0, mk(4'd2, 0, 0, 0));
    tk(3'b100, 0, mk(4'd3, 0, 0, 0));
    tk(3'b001, 0, mk(4'hA, 1, 0, 0));
    tk(3'b000, 0, mk(4'hA, 1, 0, 0));
    tk(3'b010, 0, mk(4'd0, 0, 0, 0));

    // three wrong codes -> lockout for exactly 8 ticks, presses ignored
    fail_ones(2'd0);
    for (int t = 1; t <= 7; t++) tk((t % 2 == 1) ? 3'b000 : 3'b001, 0, mk(4'hC, 0, 1, 3));
    tk(3'b001, 0, mk(4'd0, 0, 0, 0));

    // unlock, program 2,2,1,0 with last digit coinciding with prog low
    pr(3'b001, 0, mk(4'd1, 0, 0, 0));
    pr(3'b010, 0, mk(4'd2, 0, 0, 0));
    pr(3'b100, 0, mk(4'd3, 0, 0, 0));
    pr(3'b001, 0, mk(4'hA, 1, 0, 0));
    tk(3'b000, 1, mk(4'hB, 1, 0, 0));
    pr(3'b100, 1, mk(4'hB, 1, 0, 0));
    pr(3'b100, 1, mk(4'hB, 1, 0, 0));
    pr(3'b010, 1, mk(4'hB, 1, 0, 0));
    tk(3'b000, 1, mk(4'hB, 1, 0, 0));
    tk(3'b001, 0, mk(4'hA, 1, 0, 0));

    // new code unlocks
    tk(3'b000, 0, mk(4'hA, 1, 0, 0));
    tk(3'b100, 0, mk(4'd0, 0, 0, 0));
    pr(3'b100, 0, mk(4'd1, 0, 0, 0));
    pr(3'b100, 0, mk(4'd2, 0, 0, 0));
    pr(3'b010, 0, mk(4'd3, 0, 0, 0));
    pr(3'b001, 0, mk(4'hA, 1, 0, 0));

    // old code now fails
    tk(3'b000, 0, mk(4'hA, 1, 0, 0));
    tk(3'b010, 0, mk(4'd0, 0, 0, 0));
    pr(3'b001, 0, mk(4'd1, 0, 0, 0));
    pr(3'b010, 0, mk(4'd2, 0, 0, 0));
    pr(3'b100, 0, mk(4'd3, 0, 0, 0));
    pr(3'b001, 0, mk(4'd0, 0, 0, 1));

    // double press at the position expecting 1 is invalid -> failure
    pr(3'b100, 0, mk(4'd1, 0, 0, 1));
    pr(3'b100, 0, mk(4'd2, 0, 0, 1));
    pr(3'b011, 0, mk(4'd3, 0, 0, 1));
    pr(3'b001, 0, mk(4'd0, 0, 0, 2));

    // correct code clears fail count
    pr(3'b100, 0, mk(4'd1, 0, 0, 2));
    pr(3'b100, 0, mk(4'd2, 0, 0, 2));
    pr(3'b010, 0, mk(4'd3, 0, 0, 2));
    pr(3'b001, 0, mk(4'hA, 1, 0, 0));

    // program aborted after two digits
    tk(3'b000, 1, mk(4'hB, 1, 0, 0));
    pr(3'b001, 1, mk(4'hB, 1, 0, 0));
    pr(3'b010, 1, mk(4'hB, 1, 0, 0));
    tk(3'b000, 0, mk(4'hA, 1, 0, 0));
    tk(3'b100, 0, mk(4'd0, 0, 0, 0));
    pr(3'b100, 0, mk(4'd1, 0, 0, 0));
    pr(3'b100, 0, mk(4'd2, 0, 0, 0));
    pr(3'b010, 0, mk(4'd3, 0, 0, 0));
    pr(3'b001, 0, mk(4'hA, 1, 0, 0));

    // lockout again, reset at lockout tick 3
    tk(3'b000, 0, mk(4'hA, 1, 0, 0));
    tk(3'b010, 0, mk(4'd0, 0, 0, 0));
    fail_ones(2'd0);
    tk(3'b000, 0, mk(4'hC, 0, 1, 3));
    tk(3'b010, 0, mk(4'hC, 0, 1, 3));
    tk(3'b000, 0, mk(4'hC, 0, 1, 3));
    b = 3'b001;
    rst = 1'b0;
    #1 chk_out("rst_async", '0);
    @(posedge clk);
    #1 rst = 1'b1;
    cur = '0;

    // held button is not a press; default code restored
    tk(3'b001, 0, mk(4'd0, 0, 0, 0));
    tk(3'b000, 0, mk(4'd0, 0, 0, 0));
    tk(3'b001, 0, mk(4'd1, 0, 0, 0));
    pr(3'b010, 0, mk(4'd2, 0, 0, 0));
    pr(3'b100, 0, mk(4'd3, 0, 0, 0));
    pr(3'b001, 0, mk(4'hA, 1, 0, 0));

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
